// File: rtl/pu_wb_arb.sv
// Writeback arbiter: merges ALU results and buffered load returns onto the
// register file write port, with a per-register pending-load scoreboard.
module pu_wb_arb #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_NBITS = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int STARVE_MAX  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_wr_valid,
  input  logic [DEPTH_NBITS-1:0]        alu_waddr,
  input  logic [WIDTH-1:0]              alu_wdata,
  input  logic                          ld_issue,
  input  logic [DEPTH_NBITS-1:0]        ld_issue_rd,
  input  logic                          ld_ret_valid,
  output logic                          ld_ret_ready,
  input  logic [DEPTH_NBITS-1:0]        ld_ret_rd,
  input  logic [WIDTH-1:0]              ld_ret_data,
  output logic                          alu_stall,
  output logic                          rf_wr,
  output logic [DEPTH_NBITS-1:0]        rf_waddr,
  output logic [WIDTH-1:0]              rf_din,
  output logic [(1<<DEPTH_NBITS)-1:0]   busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          proto_err
);

  localparam int NREG = 1 << DEPTH_NBITS;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  logic [DEPTH_NBITS-1:0] fifo_rd_r   [FIFO_DEPTH];
  logic [WIDTH-1:0]       fifo_data_r [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [SW-1:0]          starve_r;

  logic                   fifo_empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   alu_win_s;
  logic [DEPTH_NBITS-1:0] head_rd_s;
  logic [WIDTH-1:0]       head_data_s;
  logic [SW-1:0]          starve_nxt_s;
  logic                   stall_nxt_s;
  logic [NREG-1:0]        busy_nxt_s;
  logic                   err_nxt_s;

  assign fifo_empty_s = (fifo_cnt == CW'(0));
  assign ld_ret_ready = (fifo_cnt != CW'(FIFO_DEPTH));
  assign push_s       = ld_ret_valid & ld_ret_ready;
  assign head_rd_s    = fifo_rd_r[rd_ptr_r];
  assign head_data_s  = fifo_data_r[rd_ptr_r];

  // Write-port arbitration: a forced drain beats the ALU, otherwise ALU first.
  always_comb begin
    pop_s     = 1'b0;
    alu_win_s = 1'b0;
    if (alu_stall && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else if (alu_wr_valid) begin
      alu_win_s = 1'b1;
    end else if (!fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s     = 1'b0;
      alu_win_s = 1'b0;
    end
  end

  // Starvation counter and one-cycle forced-drain request.
  always_comb begin
    starve_nxt_s = starve_r;
    stall_nxt_s  = 1'b0;
    if (pop_s || fifo_empty_s) begin
      starve_nxt_s = SW'(0);
    end else if (alu_win_s) begin
      if (starve_r == SW'(STARVE_MAX - 1)) begin
        starve_nxt_s = SW'(0);
        stall_nxt_s  = 1'b1;
      end else begin
        starve_nxt_s = starve_r + SW'(1);
      end
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Scoreboard update (issue set overrides same-cycle pop clear) and error detection.
  always_comb begin
    busy_nxt_s = busy;
    if (pop_s) begin
      busy_nxt_s[head_rd_s] = 1'b0;
    end else begin
      busy_nxt_s = busy;
    end
    if (ld_issue) begin
      busy_nxt_s[ld_issue_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    err_nxt_s = proto_err
              | (ld_ret_valid & ~ld_ret_ready)
              | (alu_stall & alu_wr_valid)
              | (ld_issue & busy[ld_issue_rd]);
  end

  // FIFO storage; contents are meaningless until counted in, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_rd_r[wr_ptr_r]   <= ld_ret_rd;
      fifo_data_r[wr_ptr_r] <= ld_ret_data;
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= PW'(0);
      rd_ptr_r  <= PW'(0);
      fifo_cnt  <= CW'(0);
      starve_r  <= SW'(0);
      alu_stall <= 1'b0;
      busy      <= NREG'(0);
      proto_err <= 1'b0;
      rf_wr     <= 1'b0;
      rf_waddr  <= DEPTH_NBITS'(0);
      rf_din    <= WIDTH'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      starve_r  <= starve_nxt_s;
      alu_stall <= stall_nxt_s;
      busy      <= busy_nxt_s;
      proto_err <= err_nxt_s;
      rf_wr     <= pop_s | alu_win_s;
      if (pop_s) begin
        rf_waddr <= head_rd_s;
        rf_din   <= head_data_s;
      end else if (alu_win_s) begin
        rf_waddr <= alu_waddr;
        rf_din   <= alu_wdata;
      end else begin
        rf_waddr <= DEPTH_NBITS'(0);
        rf_din   <= WIDTH'(0);
      end
    end
  end

endmodule

// File: tb/tb_pu_wb_arb.sv
// Directed bench for pu_wb_arb: expected register-file writes are queued at
// stimulus time and checked by a separate monitor whenever rf_wr is seen.
module tb_pu_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_wr_valid = 1'b0;
  logic [4:0]  alu_waddr = 5'd0;
  logic [31:0] alu_wdata = 32'd0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = 5'd0;
  logic        ld_ret_valid = 1'b0;
  logic        ld_ret_ready;
  logic [4:0]  ld_ret_rd = 5'd0;
  logic [31:0] ld_ret_data = 32'd0;
  logic        alu_stall;
  logic        rf_wr;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_din;
  logic [31:0] busy;
  logic [2:0]  fifo_cnt;
  logic        proto_err;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];

  pu_wb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wr_valid(alu_wr_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_ret_valid(ld_ret_valid), .ld_ret_ready(ld_ret_ready),
    .ld_ret_rd(ld_ret_rd), .ld_ret_data(ld_ret_data),
    .alu_stall(alu_stall), .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_din(rf_din),
    .busy(busy), .fifo_cnt(fifo_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drive(input logic av, input logic [4:0] wa, input logic [31:0] wd,
                       input logic li, input logic [4:0] lrd,
                       input logic rv, input logic [4:0] rrd, input logic [31:0] rdat);
    alu_wr_valid = av; alu_waddr = wa; alu_wdata = wd;
    ld_issue = li; ld_issue_rd = lrd;
    ld_ret_valid = rv; ld_ret_rd = rrd; ld_ret_data = rdat;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every write seen on the port must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rf_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_waddr, rf_din}, 64'd0);
      end else begin
        chk("rf_write", {27'd0, rf_waddr, rf_din}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_rf_wr", rf_wr, 1'b0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_cnt", fifo_cnt, 3'd0);
    chk("rst_ready", ld_ret_ready, 1'b1);
    chk("rst_err", proto_err, 1'b0);
    chk("rst_stall", alu_stall, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // ALU only
    expect_wr(5'd5, 32'hDEADBEEF);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    chk("alu_rf_wr", rf_wr, 1'b1);
    chk("alu_busy", busy, 32'd0);
    idle();

    // Load path: write lands two cycles after the return
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0);
    chk("ld_busy_set", busy[12], 1'b1);
    expect_wr(5'd12, 32'h1234);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'h1234);
    chk("ld_no_bypass", rf_wr, 1'b0);
    chk("ld_cnt1", fifo_cnt, 3'd1);
    idle();
    chk("ld_wr", rf_wr, 1'b1);
    chk("ld_din", rf_din, 32'h1234);
    chk("ld_busy_clr", busy[12], 1'b0);
    chk("ld_cnt0", fifo_cnt, 3'd0);

    // FIFO full with ALU busy every cycle
    for (int k = 0; k < 4; k++) begin
      expect_wr(5'(1 + k), 32'(32'h100 + k));
      drive(1'b1, 5'(1 + k), 32'(32'h100 + k), (k == 0), 5'd7, 1'b1, 5'(20 + k), 32'(32'h200 + k));
    end
    chk("full_ready", ld_ret_ready, 1'b0);
    chk("full_cnt", fifo_cnt, 3'd4);
    chk("full_err_before", proto_err, 1'b0);
    expect_wr(5'd5, 32'h104);
    drive(1'b1, 5'd5, 32'h104, 1'b0, 5'd0, 1'b1, 5'd24, 32'h204);
    chk("full_err", proto_err, 1'b1);
    chk("full_cnt_drop", fifo_cnt, 3'd4);
    chk("full_busy7", busy[7], 1'b1);

    // Reset mid-traffic
    alu_wr_valid = 1'b0; ld_ret_valid = 1'b0; ld_issue = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_wr", rf_wr, 1'b0);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_cnt", fifo_cnt, 3'd0);
    chk("mid_rst_ready", ld_ret_ready, 1'b1);
    chk("mid_rst_err", proto_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // Starvation: one buffered entry, ALU valid continuously
    expect_wr(5'd2, 32'hA0);
    drive(1'b1, 5'd2, 32'hA0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99);
    for (int k = 1; k <= 8; k++) begin
      expect_wr(5'd2, 32'(32'hA0 + k));
      drive(1'b1, 5'd2, 32'(32'hA0 + k), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      if (k == 7) chk("starve_no_stall_7", alu_stall, 1'b0);
    end
    chk("starve_stall", alu_stall, 1'b1);
    chk("starve_busy9", busy[9], 1'b1);
    chk("starve_err_before", proto_err, 1'b0);
    expect_wr(5'd9, 32'h99);
    drive(1'b1, 5'd3, 32'hBAD, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    chk("starve_stall_1cyc", alu_stall, 1'b0);
    chk("starve_err", proto_err, 1'b1);
    chk("starve_busy9_clr", busy[9], 1'b0);
    chk("starve_cnt", fifo_cnt, 3'd0);
    expect_wr(5'd4, 32'hC0);
    drive(1'b1, 5'd4, 32'hC0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);

    // Collision: issue and pop of the same register in one cycle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd3, 32'h33);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
    chk("coll_busy3", busy[3], 1'b1);
    chk("coll_din", rf_din, 32'h33);
    idle();
    idle();
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
